// File: rtl/traffic_phase_controller_if.sv
// rtl/traffic_phase_controller_if.sv - board-side signal bundle for the traffic phase controller
//
// Purpose: groups the raw sensor inputs and the light/status outputs of the
// intersection sequencer into one bundle.
// Signals:
//   ped_btn_in   raw async pedestrian button, active high
//   side_car_in  raw async side-street car sensor, level, active high
//   main_light   {red, yellow, green} for the main street, one-hot
//   side_light   {red, yellow, green} for the side street, one-hot
//   walk         pedestrian walk lamp
//   ped_pending  latched pedestrian request waiting
//   state_o      current state encoding
// Modports: master drives the raw inputs, slave is the controller.

interface traffic_phase_controller_if;
    logic       ped_btn_in;
    logic       side_car_in;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       ped_pending;
    logic [2:0] state_o;

    modport master (
        output ped_btn_in,
        output side_car_in,
        input  main_light,
        input  side_light,
        input  walk,
        input  ped_pending,
        input  state_o
    );

    modport slave (
        input  ped_btn_in,
        input  side_car_in,
        output main_light,
        output side_light,
        output walk,
        output ped_pending,
        output state_o
    );
endinterface

// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - two-road intersection phase sequencer with pedestrian crossing
//
// Purpose: synchronizes the raw pedestrian button and side-street car sensor,
// latches pedestrian requests, times each phase in prescaled ticks and
// arbitrates between pedestrian and side-street service.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   io     slave side of traffic_phase_controller_if (raw inputs in,
//          lights / walk / ped_pending / state_o out)

module traffic_phase_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 100_000_000,
    parameter int GREEN_MIN   = 10,
    parameter int GREEN_MAX   = 30,
    parameter int YELLOW      = 3,
    parameter int ALL_RED     = 1,
    parameter int WALK        = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    traffic_phase_controller_if.slave     io
);

    typedef enum logic [2:0] {
        MAIN_G   = 3'd0,
        MAIN_Y   = 3'd1,
        RED1     = 3'd2,
        PED_WALK = 3'd3,
        SIDE_G   = 3'd4,
        SIDE_Y   = 3'd5,
        RED2     = 3'd6
    } state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int TW = 16;

    localparam logic [PW-1:0] P_LAST   = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_GMIN   = TW'(GREEN_MIN);
    localparam logic [TW-1:0] T_GMAX   = TW'(GREEN_MAX);
    localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW);
    localparam logic [TW-1:0] T_ALLRED = TW'(ALL_RED);
    localparam logic [TW-1:0] T_WALK   = TW'(WALK);

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    logic [SYNC_STAGES-1:0] ped_sync;
    logic [SYNC_STAGES-1:0] side_sync;
    logic                   ped_d;
    logic                   ped_s;
    logic                   ped_rise;
    logic                   side_req;

    logic [PW-1:0] presc_q;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_inc;
    logic          tick;
    logic          leave;
    logic          ped_pending_q;

    state_t state_q;
    state_t state_d;

    // Synchronizer chains; bit 0 samples the raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_sync  <= '0;
            side_sync <= '0;
            ped_d     <= 1'b0;
        end else begin
            ped_sync  <= {ped_sync[SYNC_STAGES-2:0], io.ped_btn_in};
            side_sync <= {side_sync[SYNC_STAGES-2:0], io.side_car_in};
            ped_d     <= ped_s;
        end
    end

    assign ped_s    = ped_sync[SYNC_STAGES-1];
    assign side_req = side_sync[SYNC_STAGES-1];
    assign ped_rise = ped_s & ~ped_d;

    assign tick = (presc_q == P_LAST);
    // Saturate so an indefinitely held MAIN_G never wraps below GREEN_MIN.
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    // Every transition changes state, so a state change marks a state entry.
    assign leave = (state_d != state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RED2;
            presc_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            if (leave) begin
                presc_q <= '0;
                timer_q <= '0;
            end else if (tick) begin
                presc_q <= '0;
                timer_q <= timer_inc;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    // Clear on PED_WALK entry beats a simultaneous set; presses during the
    // walk phase are already being served and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending_q <= 1'b0;
        end else if (state_d == PED_WALK && state_q != PED_WALK) begin
            ped_pending_q <= 1'b0;
        end else if (ped_rise && state_q != PED_WALK) begin
            ped_pending_q <= 1'b1;
        end
    end

    // Exit conditions are only looked at on tick, against the timer value
    // that tick would produce.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                MAIN_G: begin
                    if (timer_inc >= T_GMIN && (ped_pending_q || side_req))
                        state_d = MAIN_Y;
                end
                MAIN_Y: begin
                    if (timer_inc >= T_YELLOW)
                        state_d = RED1;
                end
                RED1: begin
                    if (timer_inc >= T_ALLRED) begin
                        if (ped_pending_q)
                            state_d = PED_WALK;
                        else if (side_req)
                            state_d = SIDE_G;
                        else
                            state_d = MAIN_G;
                    end
                end
                PED_WALK: begin
                    if (timer_inc >= T_WALK)
                        state_d = side_req ? SIDE_G : RED2;
                end
                SIDE_G: begin
                    if ((timer_inc >= T_GMIN && (!side_req || ped_pending_q)) ||
                        timer_inc >= T_GMAX)
                        state_d = SIDE_Y;
                end
                SIDE_Y: begin
                    if (timer_inc >= T_YELLOW)
                        state_d = RED2;
                end
                RED2: begin
                    if (timer_inc >= T_ALLRED)
                        state_d = MAIN_G;
                end
                default: state_d = RED2;
            endcase
        end
    end

    // Lights decode straight from the state register so reset reaches the
    // lamps without a clock.
    always_comb begin
        io.main_light = LIGHT_R;
        io.side_light = LIGHT_R;
        io.walk       = 1'b0;
        case (state_q)
            MAIN_G:   io.main_light = LIGHT_G;
            MAIN_Y:   io.main_light = LIGHT_Y;
            SIDE_G:   io.side_light = LIGHT_G;
            SIDE_Y:   io.side_light = LIGHT_Y;
            PED_WALK: io.walk       = 1'b1;
            default:  ;
        endcase
    end

    assign io.ped_pending = ped_pending_q;
    assign io.state_o     = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - directed self-checking bench for traffic_phase_controller

module tb_traffic_phase_controller;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    localparam logic [2:0] S_MAIN_G = 3'd0;
    localparam logic [2:0] S_MAIN_Y = 3'd1;
    localparam logic [2:0] S_RED1   = 3'd2;
    localparam logic [2:0] S_WALK   = 3'd3;
    localparam logic [2:0] S_SIDE_G = 3'd4;
    localparam logic [2:0] S_SIDE_Y = 3'd5;
    localparam logic [2:0] S_RED2   = 3'd6;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    traffic_phase_controller_if bus ();

    traffic_phase_controller #(
        .SYNC_STAGES(2),
        .TICK_DIV   (4),
        .GREEN_MIN  (2),
        .GREEN_MAX  (5),
        .YELLOW     (1),
        .ALL_RED    (1),
        .WALK       (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each call moves n rising edges forward, landing on a falling edge.
    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expect one state (with its lamps and pending flag) for n sampled cycles.
    task automatic hold(input string tag, input logic [2:0] st, input logic [2:0] ml,
                        input logic [2:0] sl, input logic wk, input logic pp, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.state[%0d]", tag, i), {29'd0, bus.state_o}, {29'd0, st});
            chk($sformatf("%s.main[%0d]", tag, i), {29'd0, bus.main_light}, {29'd0, ml});
            chk($sformatf("%s.side[%0d]", tag, i), {29'd0, bus.side_light}, {29'd0, sl});
            chk($sformatf("%s.walk[%0d]", tag, i), {31'd0, bus.walk}, {31'd0, wk});
            chk($sformatf("%s.pend[%0d]", tag, i), {31'd0, bus.ped_pending}, {31'd0, pp});
            adv(1);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b1;
        bus.ped_btn_in  = 1'b0;
        bus.side_car_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.state", {29'd0, bus.state_o}, 32'd6);
        chk("rst.main", {29'd0, bus.main_light}, {29'd0, R});
        chk("rst.side", {29'd0, bus.side_light}, {29'd0, R});
        chk("rst.walk", {31'd0, bus.walk}, 32'd0);
        chk("rst.pend", {31'd0, bus.ped_pending}, 32'd0);
        adv(2);
        rst_n = 1'b1;

        // Idle: RED2 for ALL_RED*TICK_DIV cycles, then MAIN_G held forever.
        hold("idle_red2", S_RED2, R, R, 1'b0, 1'b0, 4);
        hold("idle_maing", S_MAIN_G, G, R, 1'b0, 1'b0, 200);

        // Side car held: MAIN_G has run long, so exit at the first tick with side_req.
        bus.side_car_in = 1'b1;
        hold("car_maing", S_MAIN_G, G, R, 1'b0, 1'b0, 4);
        hold("car_mainy", S_MAIN_Y, Y, R, 1'b0, 1'b0, 4);
        hold("car_red1", S_RED1, R, R, 1'b0, 1'b0, 4);
        hold("car_sideg", S_SIDE_G, R, G, 1'b0, 1'b0, 20);
        hold("car_sidey", S_SIDE_Y, R, Y, 1'b0, 1'b0, 4);
        hold("car_red2", S_RED2, R, R, 1'b0, 1'b0, 4);
        hold("car_maing2", S_MAIN_G, G, R, 1'b0, 1'b0, 8);
        hold("car_mainy2", S_MAIN_Y, Y, R, 1'b0, 1'b0, 4);
        hold("car_red1b", S_RED1, R, R, 1'b0, 1'b0, 4);

        // Drop side car at timer 1: exit where timer reaches GREEN_MIN.
        hold("drop1_sideg_a", S_SIDE_G, R, G, 1'b0, 1'b0, 5);
        bus.side_car_in = 1'b0;
        hold("drop1_sideg_b", S_SIDE_G, R, G, 1'b0, 1'b0, 3);
        hold("drop1_sidey", S_SIDE_Y, R, Y, 1'b0, 1'b0, 4);
        hold("drop1_red2", S_RED2, R, R, 1'b0, 1'b0, 4);
        hold("drop1_maing", S_MAIN_G, G, R, 1'b0, 1'b0, 12);

        // Re-request the side street, then drop at timer 3: exit on the next tick.
        bus.side_car_in = 1'b1;
        hold("drop3_maing", S_MAIN_G, G, R, 1'b0, 1'b0, 4);
        hold("drop3_mainy", S_MAIN_Y, Y, R, 1'b0, 1'b0, 4);
        hold("drop3_red1", S_RED1, R, R, 1'b0, 1'b0, 4);
        hold("drop3_sideg_a", S_SIDE_G, R, G, 1'b0, 1'b0, 13);
        bus.side_car_in = 1'b0;
        hold("drop3_sideg_b", S_SIDE_G, R, G, 1'b0, 1'b0, 3);
        hold("drop3_sidey", S_SIDE_Y, R, Y, 1'b0, 1'b0, 4);
        hold("drop3_red2", S_RED2, R, R, 1'b0, 1'b0, 4);

        // Pedestrian pulse during MAIN_G at timer 2.
        hold("ped_maing", S_MAIN_G, G, R, 1'b0, 1'b0, 10);
        bus.ped_btn_in = 1'b1;
        adv(1);
        bus.ped_btn_in = 1'b0;
        chk("ped.pend_e1", {31'd0, bus.ped_pending}, 32'd0);
        adv(1);
        chk("ped.pend_e2", {31'd0, bus.ped_pending}, 32'd0);
        chk("ped.state_e2", {29'd0, bus.state_o}, {29'd0, S_MAIN_G});
        adv(1);
        chk("ped.pend_e3", {31'd0, bus.ped_pending}, 32'd1);
        chk("ped.state_e3", {29'd0, bus.state_o}, {29'd0, S_MAIN_G});
        adv(3);
        hold("ped_mainy", S_MAIN_Y, Y, R, 1'b0, 1'b1, 4);
        hold("ped_red1", S_RED1, R, R, 1'b0, 1'b1, 4);
        hold("ped_walk", S_WALK, R, R, 1'b1, 1'b0, 8);
        hold("ped_red2", S_RED2, R, R, 1'b0, 1'b0, 4);

        // Both requesters: pedestrian first, then straight to SIDE_G.
        hold("both_maing", S_MAIN_G, G, R, 1'b0, 1'b0, 4);
        bus.ped_btn_in  = 1'b1;
        bus.side_car_in = 1'b1;
        adv(1);
        bus.ped_btn_in = 1'b0;
        chk("both.pend_e1", {31'd0, bus.ped_pending}, 32'd0);
        adv(1);
        chk("both.pend_e2", {31'd0, bus.ped_pending}, 32'd0);
        adv(1);
        chk("both.pend_e3", {31'd0, bus.ped_pending}, 32'd1);
        chk("both.state_e3", {29'd0, bus.state_o}, {29'd0, S_MAIN_G});
        adv(1);
        hold("both_mainy", S_MAIN_Y, Y, R, 1'b0, 1'b1, 4);
        hold("both_red1", S_RED1, R, R, 1'b0, 1'b1, 4);
        hold("both_walk", S_WALK, R, R, 1'b1, 1'b0, 8);
        chk("both.sideg", {29'd0, bus.state_o}, {29'd0, S_SIDE_G});

        // Latch another request in SIDE_G, then reset between edges.
        bus.ped_btn_in = 1'b1;
        adv(1);
        bus.ped_btn_in = 1'b0;
        adv(2);
        chk("mid.pend", {31'd0, bus.ped_pending}, 32'd1);
        chk("mid.state", {29'd0, bus.state_o}, {29'd0, S_SIDE_G});
        chk("mid.side", {29'd0, bus.side_light}, {29'd0, G});
        rst_n = 1'b0;
        #1;
        chk("arst.state", {29'd0, bus.state_o}, 32'd6);
        chk("arst.main", {29'd0, bus.main_light}, {29'd0, R});
        chk("arst.side", {29'd0, bus.side_light}, {29'd0, R});
        chk("arst.walk", {31'd0, bus.walk}, 32'd0);
        chk("arst.pend", {31'd0, bus.ped_pending}, 32'd0);
        adv(2);
        chk("arst.held", {29'd0, bus.state_o}, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
